// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte and its frame configuration, then
// sequences the serializer through START/DATA/PARITY/STOP and muxes the line bit.
module uart_tx_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int STOP_BITS  = 1,
    parameter int WDOG_LIMIT = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DATA_VALID,
    input  logic [BUS_WIDTH-1:0] P_DATA,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 ser_done,
    input  logic                 ser_data,
    output logic                 ser_en,
    output logic [BUS_WIDTH-1:0] S_DATA,
    output logic                 TX_OUT,
    output logic                 Busy,
    output logic                 TX_DONE,
    output logic                 SER_ERR
);

    localparam int WDW = $clog2(WDOG_LIMIT + 1);
    localparam int SCW = 2;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state_q,    state_d;
    logic [BUS_WIDTH-1:0] sdata_q,    sdata_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_typ_q,  par_typ_d;
    logic                 par_bit_q,  par_bit_d;
    logic [WDW-1:0]       wdog_q,     wdog_d;
    logic [SCW-1:0]       stop_cnt_q, stop_cnt_d;
    logic                 ser_err_q,  ser_err_d;

    logic last_stop;
    logic wdog_last;
    logic accept;

    assign last_stop = (state_q == STOP) && (stop_cnt_q == SCW'(STOP_BITS - 1));
    assign wdog_last = (wdog_q == WDW'(WDOG_LIMIT - 1));
    // Acceptance in the final stop cycle chains frames with no idle gap.
    assign accept    = DATA_VALID && ((state_q == IDLE) || last_stop);

    always_comb begin
        state_d    = state_q;
        sdata_d    = sdata_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bit_d  = par_bit_q;
        wdog_d     = wdog_q;
        stop_cnt_d = stop_cnt_q;
        ser_err_d  = ser_err_q;

        case (state_q)
            IDLE:   state_d = IDLE;
            START:  state_d = DATA;
            DATA: begin
                wdog_d = wdog_q + WDW'(1);
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else if (wdog_last) begin
                    ser_err_d = 1'b1;
                    state_d   = STOP;
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                if (last_stop) begin
                    stop_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + SCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sdata_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_bit_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
            wdog_d    = '0;
            ser_err_d = 1'b0;
            state_d   = START;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sdata_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            wdog_q     <= '0;
            stop_cnt_q <= '0;
            ser_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdata_q    <= sdata_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bit_q  <= par_bit_d;
            wdog_q     <= wdog_d;
            stop_cnt_q <= stop_cnt_d;
            ser_err_q  <= ser_err_d;
        end
    end

    always_comb begin
        TX_OUT  = 1'b1;
        Busy    = 1'b0;
        ser_en  = 1'b0;
        TX_DONE = 1'b0;
        case (state_q)
            START: begin
                TX_OUT = 1'b0;
                Busy   = 1'b1;
                ser_en = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                Busy   = 1'b1;
                ser_en = 1'b1;
            end
            PARITY: begin
                TX_OUT = par_bit_q;
                Busy   = 1'b1;
            end
            STOP: begin
                Busy    = 1'b1;
                TX_DONE = last_stop;
            end
            default: ;
        endcase
    end

    assign S_DATA  = sdata_q;
    assign SER_ERR = ser_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one-stop and two-stop instances driven from shared
// inputs, each fed by an LSB-first serializer model that loads on the START cycle.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       DATA_VALID = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       done_en = 1'b1;

    logic       ser_done, ser_data, ser_en, TX_OUT, Busy, TX_DONE, SER_ERR;
    logic [7:0] S_DATA;
    logic       ser_done2, ser_data2, ser_en2, TX_OUT2, Busy2, TX_DONE2, SER_ERR2;
    logic [7:0] S_DATA2;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.BUS_WIDTH(8), .STOP_BITS(1), .WDOG_LIMIT(12)) dut (
        .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .P_DATA(P_DATA),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done), .ser_data(ser_data),
        .ser_en(ser_en), .S_DATA(S_DATA), .TX_OUT(TX_OUT), .Busy(Busy),
        .TX_DONE(TX_DONE), .SER_ERR(SER_ERR)
    );

    uart_tx_ctrl #(.BUS_WIDTH(8), .STOP_BITS(2), .WDOG_LIMIT(12)) dut2 (
        .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .P_DATA(P_DATA),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done2), .ser_data(ser_data2),
        .ser_en(ser_en2), .S_DATA(S_DATA2), .TX_OUT(TX_OUT2), .Busy(Busy2),
        .TX_DONE(TX_DONE2), .SER_ERR(SER_ERR2)
    );

    // Serializer models: load on the rising ser_en, shift once per DATA cycle.
    logic [1:0]      sen, prev;
    logic [1:0][7:0] sh;
    logic [1:0][4:0] cnt;
    logic [1:0][7:0] sdat;
    assign sen     = {ser_en2, ser_en};
    assign sdat[0] = S_DATA;
    assign sdat[1] = S_DATA2;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev <= '0;
            sh   <= '0;
            cnt  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                prev[k] <= sen[k];
                if (sen[k] && !prev[k]) begin
                    sh[k]  <= sdat[k];
                    cnt[k] <= '0;
                end else if (sen[k]) begin
                    sh[k]  <= sh[k] >> 1;
                    cnt[k] <= cnt[k] + 5'd1;
                end
            end
        end
    end

    assign ser_data  = sh[0][0];
    assign ser_data2 = sh[1][0];
    assign ser_done  = done_en && sen[0] && prev[0] && (cnt[0] == 5'd7);
    assign ser_done2 = done_en && sen[1] && prev[1] && (cnt[1] == 5'd7);

    // Leaves the caller at the falling edge inside the START cycle.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        DATA_VALID = 1'b1; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        @(negedge CLK);
        DATA_VALID = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((Busy || Busy2) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        nchk++;
        if (Busy || Busy2) begin
            nerr++;
            $display("FAIL wait_idle: Busy=%b Busy2=%b, required both 0 within 60 cycles", Busy, Busy2);
        end
    endtask

    // Walks a one-stop frame from its START cycle; pulse_at injects an ignored request.
    task automatic walk_frame(input string nm, input logic [15:0] exp_tx, input int len,
                              input int pulse_at);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge CLK);
            if (i == pulse_at) begin
                DATA_VALID = 1'b1; P_DATA = 8'hFF;
            end else if (i == pulse_at + 1) begin
                DATA_VALID = 1'b0;
            end
            nchk++;
            if (TX_OUT !== exp_tx[i]) begin
                nerr++;
                $display("FAIL %s tx[%0d]: got %b, required %b", nm, i, TX_OUT, exp_tx[i]);
            end
            nchk++;
            if (Busy !== 1'b1) begin
                nerr++;
                $display("FAIL %s busy[%0d]: got %b, required 1", nm, i, Busy);
            end
            nchk++;
            if (TX_DONE !== 1'(i == len - 1)) begin
                nerr++;
                $display("FAIL %s done[%0d]: got %b, required %b", nm, i, TX_DONE, i == len - 1);
            end
            nchk++;
            if (ser_en !== 1'(i < 9)) begin
                nerr++;
                $display("FAIL %s ser_en[%0d]: got %b, required %b", nm, i, ser_en, i < 9);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        nchk++;
        if ({TX_OUT, Busy, ser_en, TX_DONE, SER_ERR} !== 5'b10000 || S_DATA !== 8'h00) begin
            nerr++;
            $display("FAIL reset: tx/busy/sen/done/err=%b sdata=%h, required 10000 00",
                     {TX_OUT, Busy, ser_en, TX_DONE, SER_ERR}, S_DATA);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            nerr++;
            $display("FAIL reset_idle: busy=%b tx=%b, required 0 1", Busy, TX_OUT);
        end
    endtask

    task automatic test_even_parity();
        send(8'hA5, 1'b1, 1'b0);
        nchk++;
        if (S_DATA !== 8'hA5) begin
            nerr++;
            $display("FAIL even_sdata: got %h, required a5", S_DATA);
        end
        walk_frame("even", 16'h054A, 11, 99);
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            nerr++;
            $display("FAIL even_after: busy=%b tx=%b, required 0 1", Busy, TX_OUT);
        end
        wait_idle();
    endtask

    task automatic test_odd_parity();
        send(8'h01, 1'b1, 1'b1);
        walk_frame("odd", 16'h0402, 11, 99);
        wait_idle();
    endtask

    task automatic test_no_parity();
        send(8'h01, 1'b0, 1'b0);
        walk_frame("nopar", 16'h0202, 10, 99);
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0) begin
            nerr++;
            $display("FAIL nopar_len: busy=%b after 10 cycles, required 0", Busy);
        end
        wait_idle();
    endtask

    task automatic test_two_stop();
        logic [15:0] exp2 = 16'h0D4A;
        send(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge CLK);
            nchk++;
            if (TX_OUT2 !== exp2[i] || Busy2 !== 1'b1 || TX_DONE2 !== 1'(i == 11)) begin
                nerr++;
                $display("FAIL stop2[%0d]: tx=%b busy=%b done=%b, required %b 1 %b",
                         i, TX_OUT2, Busy2, TX_DONE2, exp2[i], i == 11);
            end
        end
        @(negedge CLK);
        nchk++;
        if (Busy2 !== 1'b0) begin
            nerr++;
            $display("FAIL stop2_end: busy=%b, required 0", Busy2);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        DATA_VALID = 1'b1; P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        @(negedge CLK);
        P_DATA = 8'hC3;
        walk_frame("b2b1", 16'h0478, 11, 99);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        nchk++;
        if (S_DATA !== 8'hC3) begin
            nerr++;
            $display("FAIL b2b_sdata: got %h, required c3", S_DATA);
        end
        walk_frame("b2b2", 16'h0586, 11, 99);
        wait_idle();
    endtask

    task automatic test_watchdog();
        done_en = 1'b0;
        send(8'h55, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            nchk++;
            if (Busy !== 1'b1 || ser_en !== 1'b1 || SER_ERR !== 1'b0) begin
                nerr++;
                $display("FAIL wdog_data[%0d]: busy=%b sen=%b err=%b, required 1 1 0",
                         i, Busy, ser_en, SER_ERR);
            end
        end
        @(negedge CLK);
        nchk++;
        if ({TX_OUT, ser_en, TX_DONE, SER_ERR} !== 4'b1011) begin
            nerr++;
            $display("FAIL wdog_stop: tx/sen/done/err=%b, required 1011",
                     {TX_OUT, ser_en, TX_DONE, SER_ERR});
        end
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0 || SER_ERR !== 1'b1) begin
            nerr++;
            $display("FAIL wdog_sticky: busy=%b err=%b, required 0 1", Busy, SER_ERR);
        end
        wait_idle();
        done_en = 1'b1;
        send(8'h01, 1'b0, 1'b0);
        nchk++;
        if (SER_ERR !== 1'b0) begin
            nerr++;
            $display("FAIL wdog_clear: err=%b, required 0", SER_ERR);
        end
        walk_frame("wdog_next", 16'h0202, 10, 99);
        wait_idle();
    endtask

    task automatic test_ignored_request();
        send(8'h01, 1'b0, 1'b0);
        walk_frame("ignore", 16'h0202, 10, 3);
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            nerr++;
            $display("FAIL ignore_extra: busy=%b tx=%b, required 0 1", Busy, TX_OUT);
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        send(8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b1) begin
            nerr++;
            $display("FAIL mrst_pre: busy=%b, required 1", Busy);
        end
        #2 RST = 1'b0;
        #1;
        nchk++;
        if ({TX_OUT, Busy, ser_en, TX_DONE} !== 4'b1000 || S_DATA !== 8'h00) begin
            nerr++;
            $display("FAIL mrst_async: tx/busy/sen/done=%b sdata=%h, required 1000 00",
                     {TX_OUT, Busy, ser_en, TX_DONE}, S_DATA);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        nchk++;
        if (Busy !== 1'b0 || TX_OUT !== 1'b1 || ser_en !== 1'b0) begin
            nerr++;
            $display("FAIL mrst_idle: busy=%b tx=%b sen=%b, required 0 1 0", Busy, TX_OUT, ser_en);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_two_stop();
        test_back_to_back();
        test_watchdog();
        test_ignored_request();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path. It accepts a parallel byte with a valid strobe and latches the byte and the frame configuration. It sequences the external serializer through start, data, parity and stop phases, and muxes start, data, parity and stop bits onto the line. One line bit is sent per CLK cycle, because CLK is the baud-rate clock.

Parameters:
BUS_WIDTH, 8, data word width; also the width of S_DATA and the serializer word.
STOP_BITS, 1, number of stop-bit cycles per frame; legal values are 1 or 2.
WDOG_LIMIT, 12, maximum DATA-state cycles allowed without ser_done before the frame is aborted.

Ports:
CLK  in  1  baud clock; all state changes on the rising edge.
RST  in  1  asynchronous, active-low reset.
DATA_VALID  in  1  request to send P_DATA; sampled only in IDLE and STOP.
P_DATA  in  BUS_WIDTH  byte to transmit.
PAR_EN  in  1  parity enable; latched with the data.
PAR_TYP  in  1  parity type, 0 = even, 1 = odd; latched with the data.
ser_done  in  1  serializer has driven its last data bit this cycle.
ser_data  in  1  current serial data bit from the serializer.
ser_en  out  1  serializer enable.
S_DATA  out  BUS_WIDTH  latched byte presented to the serializer.
TX_OUT  out  1  UART line; idles high.
Busy  out  1  frame in progress.
TX_DONE  out  1  one-cycle pulse in the final stop cycle of each frame.
SER_ERR  out  1  sticky watchdog-abort flag.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; S_DATA = 0; latched parity enable, type and parity bit = 0; watchdog and stop counters = 0; SER_ERR = 0.
  - Outputs take their IDLE values immediately: TX_OUT = 1, Busy = 0, ser_en = 0, TX_DONE = 0.
  - Reset mid-frame abandons the frame with no stop bit sent.
- Outputs are combinational decodes of the registered state: Moore outputs, except TX_OUT in DATA, which is ser_data passed through.
- Accept event (DATA_VALID = 1 while in IDLE or in the last STOP cycle). On that edge:
  - S_DATA <= P_DATA.
  - Parity enable and type are latched.
  - Parity bit <= ^P_DATA for even, ~^P_DATA for odd.
  - Watchdog counter <= 0; SER_ERR <= 0.
  - Next state = START.
- DATA_VALID in any other state is ignored; no queueing.
- IDLE: TX_OUT = 1, Busy = 0, ser_en = 0. Stays in IDLE until an accept event.
- START: exactly 1 cycle. TX_OUT = 0, Busy = 1, ser_en = 1 (serializer loads S_DATA). Next state = DATA.
- DATA: TX_OUT = ser_data, Busy = 1, ser_en = 1. The watchdog increments each cycle.
  - If ser_done = 1: this cycle is the last data bit. Next state = PARITY if parity is enabled, else STOP.
  - Else if the watchdog reaches WDOG_LIMIT-1: SER_ERR <= 1, next state = STOP, parity phase skipped.
  - If ser_done and the watchdog limit occur together, ser_done wins (no error).
- PARITY: exactly 1 cycle. TX_OUT = latched parity bit, Busy = 1, ser_en = 0. Next state = STOP.
- STOP: STOP_BITS cycles, counted by the stop counter. TX_OUT = 1, Busy = 1, ser_en = 0.
  - TX_DONE = 1 in the final stop cycle only.
  - After the final stop cycle: next state = START on an accept event (back-to-back frames, no idle cycle), else IDLE.
- Frame length, counted from the START cycle to the final STOP cycle inclusive: 1 + (data cycles) + parity enable + STOP_BITS. With a conforming 8-bit serializer this is 11 cycles with parity, 10 without.
- P_DATA, PAR_EN and PAR_TYP may change freely after acceptance; the frame uses the latched values.

Test Plan:
- Even parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, serializer model gives ser_done on the 8th DATA cycle -> TX_OUT sequence 0, 1,0,1,0,0,1,0,1, 0, 1; TX_DONE pulses on cycle 11; Busy = 1 for 11 cycles.
- Odd parity, no parity, two stop bits:
  - P_DATA = 0x01, PAR_TYP = 1 -> parity bit = 0.
  - P_DATA = 0x01, PAR_EN = 0 -> 10-cycle frame with no parity cycle.
  - STOP_BITS = 2 -> two high stop cycles; TX_DONE only on the second.
- Back-to-back: DATA_VALID held high with 0x3C then 0xC3 -> second START immediately follows the first frame's stop cycle; Busy never drops; S_DATA = 0xC3 during the second frame.
- Watchdog: ser_done held 0 -> exit DATA after 12 cycles, SER_ERR = 1, no parity cycle, one stop cycle, TX_DONE pulses. Next accepted frame clears SER_ERR.
- Ignored request and reset:
  - DATA_VALID pulsed during DATA -> no effect on the current frame, no extra frame sent.
  - RST asserted mid-DATA -> TX_OUT = 1, Busy = 0, ser_en = 0 without waiting for a clock edge; IDLE after release.
